// File: rtl/uart_stim_pkg.sv
// uart_stim_pkg: shared types for the UART stimulus transmitter.
// Frame state encoding, character-width codes and latched frame config.
package uart_stim_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  typedef struct packed {
    logic [2:0] last_idx;
    logic       par_en;
    logic       stop2;
  } frame_cfg_t;

  // Index of the final data bit for a cfg_bits code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
    logic [2:0] r;
    r = 3'd7;
    unique case (bits)
      BITS_5: r = 3'd4;
      BITS_6: r = 3'd5;
      BITS_7: r = 3'd6;
      BITS_8: r = 3'd7;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// uart_stim_fifo: small character buffer in front of the serializer.
// Power-of-two depth so the pointers wrap on their own.
module uart_stim_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       sys_clk_i,
  input  logic       rstn_i,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge sys_clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_stim_tx.sv
// uart_stim_tx: buffered UART transmitter feeding the udma_uart RX pin.
// Frames are start, 5-8 data bits LSB first, optional even parity, 1-2 stops.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_stop_bits_i,
  input  logic [7:0]       char_i,
  input  logic             char_valid_i,
  output logic             char_ready_o,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic             done_o
);

  tx_state_t        state;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       shreg;
  logic             par;
  frame_cfg_t       cfg_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       push;
  logic       pop;
  logic       cnt_zero;
  logic       last_stop;

  assign char_ready_o = ~fifo_full;
  assign push         = char_valid_i & ~fifo_full;
  assign cnt_zero     = (baud_cnt == '0);
  assign last_stop    = (state == TX_STOP) & cnt_zero
                      & (stop_idx | ~cfg_q.stop2);
  // Popping at the end of the last stop bit keeps frames back-to-back.
  assign pop          = ~fifo_empty & ((state == TX_IDLE) | last_stop);
  assign busy_o       = (state != TX_IDLE);
  assign done_o       = last_stop;

  uart_stim_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .sys_clk_i(sys_clk_i),
    .rstn_i   (rstn_i),
    .push     (push),
    .wdata    (char_i),
    .pop      (pop),
    .rdata    (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= TX_IDLE;
      uart_tx_o <= 1'b1;
      baud_cnt  <= '0;
      div_q     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par       <= 1'b0;
      cfg_q     <= '0;
    end else if (pop) begin
      state        <= TX_START;
      uart_tx_o    <= 1'b0;
      baud_cnt     <= cfg_div_i;
      div_q        <= cfg_div_i;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= fifo_data;
      par          <= 1'b0;
      cfg_q.last_idx <= last_bit_idx(cfg_bits_i);
      cfg_q.par_en <= cfg_parity_en_i;
      cfg_q.stop2  <= cfg_stop_bits_i;
    end else begin
      unique case (state)
        TX_IDLE: begin
          uart_tx_o <= 1'b1;
        end
        TX_START: begin
          if (cnt_zero) begin
            state     <= TX_DATA;
            uart_tx_o <= shreg[0];
            par       <= shreg[0];
            shreg     <= shreg >> 1;
            bit_idx   <= '0;
            baud_cnt  <= div_q;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (!cnt_zero) begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end else if (bit_idx == cfg_q.last_idx) begin
            baud_cnt <= div_q;
            stop_idx <= 1'b0;
            if (cfg_q.par_en) begin
              state     <= TX_PARITY;
              uart_tx_o <= par;
            end else begin
              state     <= TX_STOP;
              uart_tx_o <= 1'b1;
            end
          end else begin
            bit_idx   <= bit_idx + 3'd1;
            uart_tx_o <= shreg[0];
            par       <= par ^ shreg[0];
            shreg     <= shreg >> 1;
            baud_cnt  <= div_q;
          end
        end
        TX_PARITY: begin
          if (cnt_zero) begin
            state     <= TX_STOP;
            uart_tx_o <= 1'b1;
            stop_idx  <= 1'b0;
            baud_cnt  <= div_q;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        TX_STOP: begin
          if (!cnt_zero) begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end else if (cfg_q.stop2 && !stop_idx) begin
            stop_idx <= 1'b1;
            baud_cnt <= div_q;
          end else begin
            state     <= TX_IDLE;
            uart_tx_o <= 1'b1;
          end
        end
        default: begin
          state     <= TX_IDLE;
          uart_tx_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// tb_uart_stim_tx: directed and random frames against a bit-list model.
// Expected line levels are expanded per clock from the frame rules.
module tb_uart_stim_tx;

  localparam int DIV_W = 16;

  logic             sys_clk_i = 1'b0;
  logic             rstn_i    = 1'b1;
  logic [DIV_W-1:0] cfg_div_i = '0;
  logic [1:0]       cfg_bits_i = 2'b11;
  logic             cfg_parity_en_i = 1'b0;
  logic             cfg_stop_bits_i = 1'b0;
  logic [7:0]       char_i = '0;
  logic             char_valid_i = 1'b0;
  logic             char_ready_o;
  logic             uart_tx_o;
  logic             busy_o;
  logic             done_o;

  uart_stim_tx #(
    .DIV_W     (DIV_W),
    .FIFO_DEPTH(4)
  ) dut (
    .sys_clk_i      (sys_clk_i),
    .rstn_i         (rstn_i),
    .cfg_div_i      (cfg_div_i),
    .cfg_bits_i     (cfg_bits_i),
    .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_stop_bits_i(cfg_stop_bits_i),
    .char_i         (char_i),
    .char_valid_i   (char_valid_i),
    .char_ready_o   (char_ready_o),
    .uart_tx_o      (uart_tx_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int cyc = 0;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         exp_q[$];
  bit         done_q[$];
  logic [7:0] chars[$];
  int         acc_at[$];
  int         chg_cyc = 0;
  logic [DIV_W-1:0] chg_div = '0;
  bit         chk_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One frame as a list of bit levels, each held div+1 clocks.
  function automatic void add_frame(input logic [7:0] c, input int div,
                                    input int bits, input bit par_en,
                                    input bit stop2);
    bit seq[$];
    int ones;
    int nb;
    ones = 0;
    nb = 5 + bits;
    seq.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      seq.push_back(c[i]);
      if (c[i]) ones++;
    end
    if (par_en) seq.push_back((ones % 2) == 1);
    seq.push_back(1'b1);
    if (stop2) seq.push_back(1'b1);
    foreach (seq[k])
      for (int j = 0; j <= div; j++) begin
        exp_q.push_back(seq[k]);
        done_q.push_back(1'b0);
      end
    done_q[done_q.size()-1] = 1'b1;
  endfunction

  task automatic run();
    int t0;
    @(posedge sys_clk_i);
    #1;
    t0 = cyc;
    acc_at.delete();
    fork
      begin
        foreach (chars[i]) begin
          int g;
          bit rdy;
          g = 0;
          char_i = chars[i];
          char_valid_i = 1'b1;
          do begin
            rdy = char_ready_o;
            @(posedge sys_clk_i);
            #1;
            g++;
          end while (!rdy && g < 500);
          chk("push_acc", 32'(rdy), 32'd1);
          acc_at.push_back(cyc - t0);
          char_valid_i = 1'b0;
          if (chk_full && i == 4) chk("ready_full", 32'(char_ready_o), 32'd0);
        end
      end
      begin
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        chk("pre_start", 32'({uart_tx_o, done_o, busy_o}), 32'b100);
        foreach (exp_q[k]) begin
          @(negedge sys_clk_i);
          chk($sformatf("line[%0d]", k), 32'({uart_tx_o, done_o, busy_o}),
              32'({exp_q[k], done_q[k], 1'b1}));
        end
        @(negedge sys_clk_i);
        chk("idle_after", 32'({uart_tx_o, done_o, busy_o}), 32'b100);
      end
      begin
        if (chg_cyc > 0) begin
          repeat (chg_cyc) @(posedge sys_clk_i);
          #1;
          cfg_div_i = chg_div;
        end
      end
    join
    exp_q.delete();
    done_q.delete();
    chars.delete();
    chg_cyc = 0;
    chk_full = 1'b0;
  endtask

  task automatic set_cfg(input int div, input int bits, input bit p,
                         input bit s2);
    cfg_div_i = DIV_W'(div);
    cfg_bits_i = 2'(bits);
    cfg_parity_en_i = p;
    cfg_stop_bits_i = s2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int flen;
    bit bad_idle;
    logic [7:0] c1;
    logic [7:0] c2;

    // Reset
    #2 rstn_i = 1'b0;
    #1 chk("rst_async", 32'({uart_tx_o, char_ready_o, busy_o, done_o}), 32'b1100);
    repeat (3) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    chk("rst_hold", 32'({uart_tx_o, char_ready_o, busy_o, done_o}), 32'b1100);
    rstn_i = 1'b1;
    @(negedge sys_clk_i);
    chk("rst_rel", 32'({uart_tx_o, char_ready_o, busy_o, done_o}), 32'b1100);

    // 8N1 div=3, 8'h15
    set_cfg(3, 3, 1'b0, 1'b0);
    add_frame(8'h15, 3, 3, 1'b0, 1'b0);
    chars.push_back(8'h15);
    run();

    // 8E1 div=3, 8'h56
    set_cfg(3, 3, 1'b1, 1'b0);
    add_frame(8'h56, 3, 3, 1'b1, 1'b0);
    chars.push_back(8'h56);
    run();

    // 5 bits, 2 stops, div=0, 8'hFF
    set_cfg(0, 0, 1'b0, 1'b1);
    add_frame(8'hFF, 0, 0, 1'b0, 1'b1);
    chars.push_back(8'hFF);
    run();

    // Six chars through a 4-deep FIFO, div=1 8N1
    set_cfg(1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      c1 = 8'($urandom);
      chars.push_back(c1);
      add_frame(c1, 1, 3, 1'b0, 1'b0);
    end
    chk_full = 1'b1;
    run();
    flen = 2 * 10;
    for (int i = 0; i < 5; i++) chk("acc_edge", 32'(acc_at[i]), 32'(i + 1));
    chk("stall_edge", 32'(acc_at[5]), 32'(3 + flen));

    // Reset mid-DATA with two chars queued
    set_cfg(3, 3, 1'b0, 1'b0);
    @(posedge sys_clk_i);
    #1;
    char_i = 8'h00;
    char_valid_i = 1'b1;
    repeat (3) @(posedge sys_clk_i);
    #1;
    char_valid_i = 1'b0;
    repeat (5) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    chk("pre_rst", 32'({uart_tx_o, busy_o, char_ready_o}), 32'b011);
    #2 rstn_i = 1'b0;
    #1 chk("mid_rst", 32'({uart_tx_o, char_ready_o, busy_o, done_o}), 32'b1100);
    repeat (2) @(negedge sys_clk_i);
    rstn_i = 1'b1;
    bad_idle = 1'b0;
    repeat (60) begin
      @(negedge sys_clk_i);
      if (!uart_tx_o || busy_o || !char_ready_o) bad_idle = 1'b1;
    end
    chk("post_rst_idle", 32'(bad_idle), 32'd0);

    // Divider change mid-frame applies from the next pop
    set_cfg(3, 3, 1'b0, 1'b0);
    c1 = 8'($urandom);
    c2 = 8'($urandom);
    chars.push_back(c1);
    chars.push_back(c2);
    add_frame(c1, 3, 3, 1'b0, 1'b0);
    add_frame(c2, 7, 3, 1'b0, 1'b0);
    chg_cyc = 6;
    chg_div = DIV_W'(7);
    run();

    // Random batches
    repeat (6) begin
      int dv;
      int bt;
      bit pe;
      bit s2;
      int n;
      dv = int'($urandom_range(0, 3));
      bt = int'($urandom_range(0, 3));
      pe = 1'($urandom);
      s2 = 1'($urandom);
      n = int'($urandom_range(1, 4));
      set_cfg(dv, bt, pe, s2);
      for (int i = 0; i < n; i++) begin
        c1 = 8'($urandom);
        chars.push_back(c1);
        add_frame(c1, dv, bt, pe, s2);
      end
      run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
